// File: rtl/tau_pkg.sv
// Shared definitions for the fetch path.
//   PC_W / IW       : default PC and instruction word widths
//   PCH_*           : pc_handle encodings understood by the pc register
//   fetch_state_t   : fetch sequencer states
package tau_pkg;

  localparam int PC_W = 24;
  localparam int IW   = 24;

  localparam logic [1:0] PCH_HOLD = 2'b00;
  localparam logic [1:0] PCH_INC  = 2'b01;
  localparam logic [1:0] PCH_LOAD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer.
// Fetches the word at pc_in from instruction memory, presents it to decode,
// then increments the PC on acceptance or loads a redirect target.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   run                     level: keep fetching
//   pc_in                   current PC value
//   pc_handle, pc_target    PC control (00 hold, 01 inc, 10 load target)
//   imem_req/addr/gnt       memory request channel
//   imem_rvalid/rdata       memory response channel (one pulse per grant)
//   instr_valid/data/ready  decode channel
//   redirect_valid/addr     jump/branch taken from execute
//   halt                    presented instruction is HALT
//   busy, halted            status
//   dbg_state               current FSM state
//
// Handshakes: a transfer happens on any rising edge where valid (req) and
// ready (gnt) are both high; the initiator holds valid and its payload
// stable until that edge. imem_rvalid is a one-cycle pulse with no
// back-pressure.
module fetch_ctrl
  import tau_pkg::*;
#(
  parameter int PC_W = tau_pkg::PC_W,
  parameter int IW   = tau_pkg::IW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic [PC_W-1:0] pc_in,
  output logic [1:0]      pc_handle,
  output logic [PC_W-1:0] pc_target,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [IW-1:0]   imem_rdata,
  output logic            instr_valid,
  output logic [IW-1:0]   instr_data,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_addr,
  input  logic            halt,
  output logic            busy,
  output logic            halted,
  output fetch_state_t    dbg_state
);

  fetch_state_t    state;
  logic            pending;
  logic [PC_W-1:0] pend_addr;

  // A response is still owed by memory when a redirect arrives in WAIT (or
  // together with a grant); the target is parked until that response is
  // drained so the stale word never reaches decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pending    <= 1'b0;
      pend_addr  <= '0;
      instr_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (redirect_valid || run) state <= ST_REQ;
        end
        ST_REQ: begin
          if (imem_gnt) begin
            if (redirect_valid) begin
              pending   <= 1'b1;
              pend_addr <= redirect_addr;
            end
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (pending || redirect_valid) begin
              pending <= 1'b0;
              state   <= ST_REQ;
            end else begin
              instr_data <= imem_rdata;
              state      <= ST_ISSUE;
            end
          end else if (redirect_valid) begin
            pending   <= 1'b1;
            pend_addr <= redirect_addr;
          end
        end
        ST_ISSUE: begin
          if (redirect_valid)   state <= ST_REQ;
          else if (instr_ready) begin
            if (halt)           state <= ST_HALT;
            else if (run)       state <= ST_REQ;
            else                state <= ST_IDLE;
          end
        end
        ST_HALT: begin
          if (redirect_valid) state <= ST_REQ;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // PC control and request signals are decoded from state so the pc register
  // updates on the same edge that leaves ISSUE/WAIT. Everything is gated by
  // rst_n so outputs read 0 while reset is held.
  always_comb begin
    pc_handle   = PCH_HOLD;
    pc_target   = '0;
    imem_req    = 1'b0;
    imem_addr   = '0;
    instr_valid = 1'b0;
    if (rst_n) begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (redirect_valid) begin
            pc_handle = PCH_LOAD;
            pc_target = redirect_addr;
          end
        end
        ST_REQ: begin
          imem_req  = 1'b1;
          imem_addr = pc_in;
          // With a grant the redirect is deferred until the response drains.
          if (redirect_valid && !imem_gnt) begin
            pc_handle = PCH_LOAD;
            pc_target = redirect_addr;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid && (pending || redirect_valid)) begin
            pc_handle = PCH_LOAD;
            pc_target = redirect_valid ? redirect_addr : pend_addr;
          end
        end
        ST_ISSUE: begin
          if (redirect_valid) begin
            pc_handle = PCH_LOAD;
            pc_target = redirect_addr;
          end else begin
            instr_valid = 1'b1;
            if (instr_ready) pc_handle = PCH_INC;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == ST_REQ) || (state == ST_WAIT) || (state == ST_ISSUE);
  assign halted    = (state == ST_HALT);
  assign dbg_state = state;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
  import tau_pkg::*;

  localparam int AW = 24;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run;
  logic [AW-1:0] pc_in;
  logic [1:0]    pc_handle;
  logic [AW-1:0] pc_target;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [DW-1:0] imem_rdata;
  logic          instr_valid;
  logic [DW-1:0] instr_data;
  logic          instr_ready;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic          halt;
  logic          busy;
  logic          halted;
  fetch_state_t  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.PC_W(AW), .IW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .pc_in(pc_in),
    .pc_handle(pc_handle), .pc_target(pc_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .halt(halt),
    .busy(busy), .halted(halted), .dbg_state(dbg_state)
  );

  // The pc register this block controls.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_in <= '0;
    else if (pc_handle == PCH_INC)  pc_in <= pc_in + 1'b1;
    else if (pc_handle == PCH_LOAD) pc_in <= pc_target;
  end

  typedef struct {
    logic          run, gnt, rvalid;
    logic [DW-1:0] rdata;
    logic          ready, rdv;
    logic [AW-1:0] raddr;
    logic          hlt;
    logic [1:0]    pch;
    logic          req;
    logic [AW-1:0] addr;
    logic          valid;
    logic [DW-1:0] data;
    logic          bsy, hltd;
    logic [AW-1:0] tgt;
  } vec_t;

  function automatic vec_t mk(
    input logic r, g, rv, input logic [DW-1:0] rd, input logic rdy, dv,
    input logic [AW-1:0] ra, input logic h,
    input logic [1:0] pch, input logic req, input logic [AW-1:0] addr,
    input logic val, input logic [DW-1:0] data, input logic bsy, hltd,
    input logic [AW-1:0] tgt);
    vec_t v;
    v.run = r; v.gnt = g; v.rvalid = rv; v.rdata = rd; v.ready = rdy;
    v.rdv = dv; v.raddr = ra; v.hlt = h;
    v.pch = pch; v.req = req; v.addr = addr; v.valid = val; v.data = data;
    v.bsy = bsy; v.hltd = hltd; v.tgt = tgt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic apply(input vec_t v);
    run = v.run; imem_gnt = v.gnt; imem_rvalid = v.rvalid; imem_rdata = v.rdata;
    instr_ready = v.ready; redirect_valid = v.rdv; redirect_addr = v.raddr; halt = v.hlt;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    chk({tag, ".pc_handle"},   32'(pc_handle),   32'(v.pch));
    chk({tag, ".pc_target"},   32'(pc_target),   32'(v.tgt));
    chk({tag, ".imem_req"},    32'(imem_req),    32'(v.req));
    chk({tag, ".imem_addr"},   32'(imem_addr),   32'(v.addr));
    chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(v.valid));
    chk({tag, ".instr_data"},  32'(instr_data),  32'(v.data));
    chk({tag, ".busy"},        32'(busy),        32'(v.bsy));
    chk({tag, ".halted"},      32'(halted),      32'(v.hltd));
  endtask

  // Drive a vector at the falling edge, check before the next rising edge.
  task automatic step(input string tag, input vec_t v);
    apply(v);
    #2;
    check_all(tag, v);
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t tbl[11];
  vec_t zero_v;

  initial begin
    zero_v = mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
    // Zero-wait memory, decode always ready, three fetches from PC 0.
    tbl[0]  = mk(1,0,0,0,        0,0,0,0, 0,0,0,0,0,        0,0,0); // IDLE
    tbl[1]  = mk(1,1,0,0,        0,0,0,0, 0,1,0,0,0,        1,0,0); // REQ @0
    tbl[2]  = mk(1,0,1,24'hA00000,0,0,0,0, 0,0,0,0,0,       1,0,0); // WAIT
    tbl[3]  = mk(1,0,0,0,        1,0,0,0, 1,0,0,1,24'hA00000,1,0,0); // ISSUE
    tbl[4]  = mk(1,1,0,0,        0,0,0,0, 0,1,1,0,24'hA00000,1,0,0); // REQ @1
    tbl[5]  = mk(1,0,1,24'hA00001,0,0,0,0, 0,0,0,0,24'hA00000,1,0,0);
    tbl[6]  = mk(1,0,0,0,        1,0,0,0, 1,0,0,1,24'hA00001,1,0,0);
    tbl[7]  = mk(1,1,0,0,        0,0,0,0, 0,1,2,0,24'hA00001,1,0,0); // REQ @2
    tbl[8]  = mk(1,0,1,24'hA00002,0,0,0,0, 0,0,0,0,24'hA00001,1,0,0);
    tbl[9]  = mk(0,0,0,0,        1,0,0,0, 1,0,0,1,24'hA00002,1,0,0); // last, run off
    tbl[10] = mk(0,0,0,0,        0,0,0,0, 0,0,0,0,24'hA00002,0,0,0); // back to IDLE

    rst_n = 1'b0;
    apply(zero_v);
    repeat (2) @(negedge clk);
    #2;
    check_all("reset", zero_v);
    chk("reset.state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) step($sformatf("zw[%0d]", i), tbl[i]);
    chk("zw.pc", 32'(pc_in), 32'd3);

    // Slow grant and stalled decode: address and data hold, one increment.
    step("sl.idle", mk(1,0,0,0,0,0,0,0, 0,0,0,0,24'hA00002,0,0,0));
    for (int i = 0; i < 4; i++)
      step($sformatf("sl.req%0d", i), mk(1,0,0,0,0,0,0,0, 0,1,3,0,24'hA00002,1,0,0));
    step("sl.gnt", mk(1,1,0,0,0,0,0,0, 0,1,3,0,24'hA00002,1,0,0));
    for (int i = 0; i < 2; i++)
      step($sformatf("sl.wait%0d", i), mk(1,0,0,0,0,0,0,0, 0,0,0,0,24'hA00002,1,0,0));
    step("sl.rv", mk(1,0,1,24'hB00003,0,0,0,0, 0,0,0,0,24'hA00002,1,0,0));
    for (int i = 0; i < 3; i++)
      step($sformatf("sl.stall%0d", i), mk(1,0,0,0,0,0,0,0, 0,0,0,1,24'hB00003,1,0,0));
    step("sl.acc", mk(0,0,0,0,1,0,0,0, 1,0,0,1,24'hB00003,1,0,0));
    chk("sl.pc", 32'(pc_in), 32'd4);
    step("sl.idle2", mk(0,0,0,0,0,0,0,0, 0,0,0,0,24'hB00003,0,0,0));

    // Redirect in ISSUE together with accept: squash, load, refetch at target.
    step("ri.idle", mk(1,0,0,0,0,0,0,0, 0,0,0,0,24'hB00003,0,0,0));
    step("ri.req",  mk(1,1,0,0,0,0,0,0, 0,1,4,0,24'hB00003,1,0,0));
    step("ri.wait", mk(1,0,1,24'hC00004,0,0,0,0, 0,0,0,0,24'hB00003,1,0,0));
    step("ri.iss",  mk(1,0,0,0,1,1,24'h000100,0, 2,0,0,0,24'hC00004,1,0,24'h000100));
    step("ri.req2", mk(1,1,0,0,0,0,0,0, 0,1,24'h000100,0,24'hC00004,1,0,0));

    // Redirect during WAIT: response dropped, load on rvalid, refetch.
    step("rw.wait", mk(1,0,0,0,0,1,24'h000040,0, 0,0,0,0,24'hC00004,1,0,0));
    step("rw.rv",   mk(1,0,1,24'hDEAD00,0,0,0,0, 2,0,0,0,24'hC00004,1,0,24'h000040));
    step("rw.req",  mk(1,1,0,0,0,0,0,0, 0,1,24'h000040,0,24'hC00004,1,0,0));
    step("rw.wt2",  mk(1,0,1,24'hC00040,0,0,0,0, 0,0,0,0,24'hC00004,1,0,0));
    step("rw.iss",  mk(1,0,0,0,0,1,24'h000005,0, 2,0,0,0,24'hC00040,1,0,24'h000005));

    // HALT at PC 5, then redirect to 0 resumes.
    step("h.req",  mk(1,1,0,0,0,0,0,0, 0,1,5,0,24'hC00040,1,0,0));
    step("h.wait", mk(1,0,1,24'hC00005,0,0,0,0, 0,0,0,0,24'hC00040,1,0,0));
    step("h.iss",  mk(1,0,0,0,1,0,0,1, 1,0,0,1,24'hC00005,1,0,0));
    for (int i = 0; i < 10; i++)
      step($sformatf("h.halt%0d", i), mk(1,0,0,0,0,0,0,0, 0,0,0,0,24'hC00005,0,1,0));
    chk("h.pc", 32'(pc_in), 32'd6);
    step("h.redir", mk(1,0,0,0,0,1,0,0, 2,0,0,0,24'hC00005,0,1,0));
    step("h.req0",  mk(1,1,0,0,0,0,0,0, 0,1,0,0,24'hC00005,1,0,0));
    chk("h.state_wait", 32'(dbg_state), 32'(ST_WAIT));

    // Reset mid-WAIT: outputs clear at once, a late response is ignored.
    apply(zero_v);
    rst_n = 1'b0;
    #1;
    check_all("rst.now", zero_v);
    chk("rst.state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("rst.late_rv", mk(0,0,1,24'hEEEEEE,0,0,0,0, 0,0,0,0,0,0,0,0));
    step("rst.idle",    zero_v);
    chk("rst.state2", 32'(dbg_state), 32'(ST_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
